ahbl_bus_mux_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer for the multi-master AHB-Lite bus mux. It decides which master's

---
 rtl/ahbl_bus_mux_arbiter.sv | 133 +++++++++++++
 tb/tb_ahbl_bus_mux_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ahbl_bus_mux_arbiter.sv
// Round-robin address-phase arbiter for the multi-master AHB-Lite mux: picks the live or buffered
// aphase that drives the slave, tracks the data-phase owner and stalls losers via HREADY.
module ahbl_bus_mux_arbiter #(
  parameter  int NM = 2,
  localparam int MW = $clog2(NM)
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [2*NM-1:0] m_htrans,
  input  logic [NM-1:0]   m_hmastlock,
  input  logic            s_hready,
  output logic [NM-1:0]   m_hreadyout,
  output logic [NM-1:0]   cap_en,
  output logic [MW-1:0]   aphase_sel,
  output logic            aphase_from_buf,
  output logic            aphase_valid,
  output logic [MW-1:0]   dphase_sel
);

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_SEQ  = 2'b11;

  logic [NM-1:0] r_pend;
  logic [NM-1:0] r_cap_q;
  logic [MW-1:0] r_gnt;
  logic [MW-1:0] r_rr_last;
  logic          r_dvalid;
  logic [MW-1:0] r_dsel;

  logic [NM-1:0] w_hro;
  logic [NM-1:0] w_live_req;
  logic [NM-1:0] w_req;
  logic [NM-1:0] w_cap;
  logic [NM-1:0] w_pend_nxt;
  logic [MW-1:0] w_winner;
  logic [1:0]    w_gnt_trans;
  logic          w_any_req;
  logic          w_hold;
  logic          w_commit;

  always_comb begin
    w_hro = '1;
    for (int m = 0; m < NM; m++) begin
      if (r_dvalid && r_dsel == MW'(m))
        w_hro[m] = s_hready;
      else if (r_pend[m] || r_cap_q[m])
        w_hro[m] = 1'b0;
    end
  end

  always_comb begin
    w_live_req = '0;
    for (int m = 0; m < NM; m++)
      w_live_req[m] = (m_htrans[2*m +: 2] != HT_IDLE) && w_hro[m];
  end

  assign w_req       = r_pend | w_live_req;
  assign w_any_req   = |w_req;
  assign w_commit    = s_hready && w_any_req;
  assign w_gnt_trans = m_htrans[2*int'(r_gnt) +: 2];
  // An owner mid-burst or holding the lock keeps the bus regardless of round-robin order.
  assign w_hold = (w_live_req[r_gnt] && (w_gnt_trans == HT_SEQ || w_gnt_trans == HT_BUSY))
                  || m_hmastlock[r_gnt];

  always_comb begin : p_arb
    logic [MW-1:0] v_idx;
    logic          v_found;
    w_winner = r_gnt;
    v_found  = 1'b0;
    v_idx    = '0;
    if (!w_hold) begin
      for (int k = 1; k <= NM; k++) begin
        v_idx = MW'((int'(r_rr_last) + k) % NM);
        if (!v_found && w_req[v_idx]) begin
          w_winner = v_idx;
          v_found  = 1'b1;
        end
      end
    end
  end

  // A stalled owner holds its own aphase on the wires, so only non-winning live requests are buffered.
  always_comb begin
    w_cap = '0;
    for (int m = 0; m < NM; m++)
      w_cap[m] = w_live_req[m]
                 && !(s_hready && w_winner == MW'(m) && !r_pend[m])
                 && !(r_dvalid && r_dsel == MW'(m) && !s_hready);
  end

  always_comb begin
    w_pend_nxt = r_pend;
    for (int m = 0; m < NM; m++) begin
      if (w_cap[m])
        w_pend_nxt[m] = 1'b1;
      else if (w_commit && w_winner == MW'(m))
        w_pend_nxt[m] = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend    <= '0;
      r_cap_q   <= '0;
      r_gnt     <= '0;
      r_rr_last <= MW'(NM - 1);
      r_dvalid  <= 1'b0;
      r_dsel    <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_cap_q <= w_cap;
      if (s_hready) begin
        if (w_any_req) begin
          r_gnt     <= w_winner;
          r_rr_last <= w_winner;
          r_dvalid  <= 1'b1;
          r_dsel    <= w_winner;
        end else begin
          r_dvalid  <= 1'b0;
        end
      end
    end
  end

  assign m_hreadyout     = HRESET ? '1 : w_hro;
  assign cap_en          = HRESET ? '0 : w_cap;
  assign aphase_valid    = !HRESET && w_any_req;
  assign aphase_sel      = HRESET ? '0 : w_winner;
  assign aphase_from_buf = !HRESET && r_pend[w_winner];
  assign dphase_sel      = r_dsel;

endmodule

// File: tb/tb_ahbl_bus_mux_arbiter.sv
// Directed bench for the 2-master AHB-Lite mux arbiter; expected outputs are queued per cycle
// by the driver and checked by an independent monitor on the falling edge.
module tb_ahbl_bus_mux_arbiter;
  localparam int NM = 2;

  localparam logic [7:0] FULL  = 8'hFF;
  localparam logic [7:0] NOSEL = 8'hF7;
  localparam logic [7:0] WAITM = 8'hF3;
  localparam logic [7:0] RSTM  = 8'hFE;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] htrans;
  logic [1:0] lock;
  logic       s_hready;
  logic [1:0] hro;
  logic [1:0] cap;
  logic       sel;
  logic       fb;
  logic       av;
  logic       ds;

  always #5 clk = ~clk;

  ahbl_bus_mux_arbiter #(.NM(NM)) dut (
    .HCLK            (clk),
    .HRESET          (rst),
    .m_htrans        (htrans),
    .m_hmastlock     (lock),
    .s_hready        (s_hready),
    .m_hreadyout     (hro),
    .cap_en          (cap),
    .aphase_sel      (sel),
    .aphase_from_buf (fb),
    .aphase_valid    (av),
    .dphase_sel      (ds)
  );

  string      q_nm[$];
  logic [7:0] q_ex[$];
  logic [7:0] q_mk[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] e(input logic [1:0] h, input logic [1:0] c, input logic s,
                                   input logic f, input logic v, input logic d);
    return {h, c, s, f, v, d};
  endfunction

  task automatic step(input logic [1:0] t0, input logic [1:0] t1, input logic l0,
                      input logic sr, input logic r, input string nm,
                      input logic [7:0] ex, input logic [7:0] mk);
    @(posedge clk);
    #1;
    htrans   = {t1, t0};
    lock     = {1'b0, l0};
    s_hready = sr;
    rst      = r;
    q_nm.push_back(nm);
    q_ex.push_back(ex);
    q_mk.push_back(mk);
  endtask

  task automatic do_reset(input string nm);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b1, {nm, "_r1"}, e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), RSTM);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b1, {nm, "_r2"}, e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), FULL);
  endtask

  always @(negedge clk) begin : mon
    string      n;
    logic [7:0] ex;
    logic [7:0] mk;
    logic [7:0] act;
    if (q_ex.size() > 0) begin
      n   = q_nm.pop_front();
      ex  = q_ex.pop_front();
      mk  = q_mk.pop_front();
      act = {hro, cap, sel, fb, av, ds};
      total++;
      if (((act ^ ex) & mk) !== 8'h00) begin
        bad++;
        $display("FAIL %s: got=%b want=%b care=%b (hro,cap,sel,buf,valid,dsel)", n, act, ex, mk);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; htrans = 4'h0; lock = 2'b00; s_hready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("init");

    // single master streaming NONSEQ
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t1_c1", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t1_c2", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t1_c3", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t1_idle", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), NOSEL);
    do_reset("t2");

    // simultaneous requests after reset
    step(2'd2, 2'd2, 1'b0, 1'b1, 1'b0, "t2_c1", e(2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "t2_c2", e(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t2_c3", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1), NOSEL);
    do_reset("t3");

    // INCR4 from master 0, master 1 arrives at beat 2
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t3_b1", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd3, 2'd2, 1'b0, 1'b1, 1'b0, "t3_b2", e(2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd3, 2'd2, 1'b0, 1'b1, 1'b0, "t3_b3", e(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd3, 2'd2, 1'b0, 1'b1, 1'b0, "t3_b4", e(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "t3_m1", e(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t3_done", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1), NOSEL);
    step(2'd2, 2'd2, 1'b0, 1'b1, 1'b0, "t3_rr", e(2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1), FULL);
    do_reset("t4");

    // two slave wait states while master 1 requests
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t4_c1", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, "t4_w1", e(2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0), WAITM);
    step(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, "t4_w2", e(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), WAITM);
    step(2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "t4_go", e(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t4_dp", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1), NOSEL);
    do_reset("t5");

    // locked sequence from master 0
    step(2'd2, 2'd0, 1'b1, 1'b1, 1'b0, "t5_c1", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "t5_c2", e(2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd2, 2'd2, 1'b1, 1'b1, 1'b0, "t5_c3", e(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "t5_c4", e(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t5_c5", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1), NOSEL);
    do_reset("t6");

    // reset while master 1 is buffered and the slave is stalling
    step(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, "t6_c1", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0), FULL);
    step(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, "t6_c2", e(2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0), WAITM);
    step(2'd0, 2'd2, 1'b0, 1'b0, 1'b1, "t6_rst", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), RSTM);
    step(2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "t6_after", e(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0), NOSEL);
    step(2'd0, 2'd2, 1'b0, 1'b1, 1'b0, "t6_pend", e(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0), FULL);

    repeat (3) @(negedge clk);
    if (q_ex.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d unchecked entries want=0", q_ex.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
